aes_key_sched_ctrl: RTL
=======================

# aes_key_sched_ctrl

Sequencer that drives the single-round `KeyExpansion` datapath ten times to build all eleven AES-128 round keys from one cipher key, and holds them for the round pipeline. Sits between the key-load interface and the cipher rounds. It accepts a key through a valid/ready handshake and supplies the round constant and chaining key to the expansion unit for each round. It stores every round key in an 11-entry register file and serves a registered read port to the round pipeline.

## Interface
- `EXP_LAT`, default 1: cycles from `exp_key_in`/`exp_rcon` valid to `exp_key_out` valid. Range 1..15.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `key_in`, in, 128: cipher key. Byte i is at `[8i+7:8i]`, so byte 0 is in `[7:0]`.
- `key_valid`, in, 1: key offer.
- `key_ready`, out, 1: high only in IDLE.
- `flush`, in, 1: abort expansion and invalidate the stored keys.
- `exp_key_in`, out, 128: previous round key to the expansion unit.
- `exp_rcon`, out, 8: round constant to the expansion unit.
- `exp_start`, out, 1: one-cycle pulse when new inputs are presented.
- `exp_key_out`, in, 128: next round key from the expansion unit.
- `busy`, out, 1: expansion in progress.
- `done`, out, 1: one-cycle pulse when round key 10 has been stored.
- `keys_valid`, out, 1: all 11 round keys are valid.
- `rk_rd_addr`, in, 4: round-key index, 0..10.
- `rk_rd_data`, out, 128: registered read data.

## Operation
- **States:** IDLE, RUN, CAPTURE.
- **IDLE:**
  - `key_ready`=1.
  - On `key_valid`&&`key_ready`: write `rk[0]`=`key_in`, drive `exp_key_in`=`key_in` and `exp_rcon`=0x01, set round=1, clear `keys_valid`, go to RUN.
- **RUN:**
  - `exp_start`=1 in the first RUN cycle only.
  - `exp_key_in` and `exp_rcon` are held stable.
  - A wait counter counts `EXP_LAT` cycles, then the state goes to CAPTURE.
- **CAPTURE:**
  - Write `rk[round]`=`exp_key_out`.
  - If round==10: pulse `done`, set `keys_valid`=1, go to IDLE.
  - Otherwise: `exp_key_in`=`exp_key_out`, `exp_rcon`=xtime(`exp_rcon`) (shift left 1, XOR 0x1b if bit 7 was set), round+1, go to RUN.
- **Round constant sequence:** 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- **Handshake:** `key_valid` outside IDLE is ignored; no key is queued. `key_in` is sampled only in the accept cycle.
- **Read port:**
  - `rk_rd_data` <= `rk[rk_rd_addr]` when `keys_valid`=1 and addr<=10, otherwise 0.
  - Read latency is 1 cycle.
- **Flush:**
  - Priority over everything else, including an accept in the same cycle.
  - Next state is IDLE; `keys_valid`, `busy` and `exp_start` are cleared.
  - The register file is not cleared, but reads return 0 until the next `done`.
- **`busy`:** equals (state != IDLE).

## Timing
- **Reset values:**
  - State IDLE, `key_ready`=1, `busy`=0, `done`=0, `keys_valid`=0, `exp_start`=0.
  - `exp_key_in`=0, `exp_rcon`=0, `rk_rd_data`=0, all `rk` entries 0.
- **Accept at edge of cycle T:**
  - RUN runs in cycles T+1..T+`EXP_LAT`.
  - CAPTURE occurs in cycle T+`EXP_LAT`+1.
- **Per round:** `EXP_LAT`+1 cycles.
- **Completion:**
  - `done` is high in the cycle after the round-10 CAPTURE, i.e. cycle T+10(`EXP_LAT`+1)+1.
  - `keys_valid` rises in the same cycle, and `key_ready` returns to 1 in that cycle.
  - For `EXP_LAT`=1, `done` is at T+21.
- **Back-to-back keys:** a new key can be accepted in the cycle `done` is high. `keys_valid` drops on that accept edge.
- **Reset mid-expansion:** returns every output to its reset value on the next edge.
- **Rcon wrap:** `exp_rcon` never advances past 0x36. The value after round 10 is not driven because the block is already in IDLE.

## Test plan
- **Reset check:** apply `rst` for 2 cycles -> all outputs at their reset values, `key_ready`=1. Reads of addresses 0..10 return 0.
- **FIPS-197 key:** key bytes 00 01 .. 0f (`128'h0f0e0d0c0b0a09080706050403020100`), `EXP_LAT`=1, using a behavioural round model -> `done` at T+21.
  - `rk[10]` bytes are 13 11 1d 7f e3 94 4a 17 f3 07 a7 8b 4d 2b 30 c5.
  - The observed `exp_rcon` sequence is 01..36.
- **Key 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c:**
  - `rk[1]` bytes are a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05.
  - `rk[10]` bytes are d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6.
  - Read at addr 11 returns 0.
- **Busy ignores new keys:** assert `key_valid` continuously with a second key during expansion -> no accept until `done`. The second key is accepted in the `done` cycle, and `keys_valid` falls on the next edge.
- **Flush mid-expansion:** assert `flush` during round 5 -> IDLE on the next cycle, `busy`=0, `done` never pulses, reads return 0. The next key then expands correctly.
- **Latency sweep:** run `EXP_LAT`=3 -> `done` at T+41, and `exp_start` pulses exactly 10 times, each (`EXP_LAT`+1) cycles apart.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer.
// Drives an external single-round KeyExpansion unit ten times, stores the eleven
// round keys in a register file and serves them through a registered read port.
module aes_key_sched_ctrl #(
   parameter int unsigned EXP_LAT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic         flush,
   output logic [127:0] exp_key_in,
   output logic [7:0]   exp_rcon,
   output logic         exp_start,
   input  logic [127:0] exp_key_out,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   input  logic [3:0]   rk_rd_addr,
   output logic [127:0] rk_rd_data
);

   typedef enum logic [1:0] {StIdle, StRun, StCapture} state_e;

   localparam logic [3:0] LastCnt   = 4'(EXP_LAT - 1);
   localparam logic [3:0] LastRound = 4'd10;
   localparam logic [3:0] MaxAddr   = 4'd10;

   state_e         state_q;
   logic [3:0]     round_q;
   logic [3:0]     cnt_q;
   logic [127:0]   exp_key_q;
   logic [7:0]     rcon_q;
   logic           exp_start_q;
   logic           done_q;
   logic           keys_valid_q;
   logic [127:0]   rd_data_q;
   logic [127:0]   rk_q [0:10];

   // GF(2^8) doubling used to step the round constant.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Sequencer, register file and read port; flush overrides any state action.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         round_q      <= '0;
         cnt_q        <= '0;
         exp_key_q    <= '0;
         rcon_q       <= '0;
         exp_start_q  <= 1'b0;
         done_q       <= 1'b0;
         keys_valid_q <= 1'b0;
         rd_data_q    <= '0;
         for (int i = 0; i < 11; i++) begin
            rk_q[i] <= '0;
         end
      end else begin
         exp_start_q <= 1'b0;
         done_q      <= 1'b0;

         // Reads are gated by the validity flag as it stands before this edge.
         if (!flush && keys_valid_q && (rk_rd_addr <= MaxAddr)) begin
            rd_data_q <= rk_q[rk_rd_addr];
         end else begin
            rd_data_q <= '0;
         end

         if (flush) begin
            state_q      <= StIdle;
            keys_valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (key_valid) begin
                     rk_q[0]      <= key_in;
                     exp_key_q    <= key_in;
                     rcon_q       <= 8'h01;
                     round_q      <= 4'd1;
                     cnt_q        <= '0;
                     keys_valid_q <= 1'b0;
                     exp_start_q  <= 1'b1;
                     state_q      <= StRun;
                  end
               end
               StRun: begin
                  if (cnt_q == LastCnt) begin
                     state_q <= StCapture;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
               StCapture: begin
                  rk_q[round_q] <= exp_key_out;
                  if (round_q == LastRound) begin
                     done_q       <= 1'b1;
                     keys_valid_q <= 1'b1;
                     state_q      <= StIdle;
                  end else begin
                     exp_key_q   <= exp_key_out;
                     rcon_q      <= xtime(rcon_q);
                     round_q     <= round_q + 4'd1;
                     cnt_q       <= '0;
                     exp_start_q <= 1'b1;
                     state_q     <= StRun;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign key_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign exp_key_in = exp_key_q;
   assign exp_rcon   = rcon_q;
   assign exp_start  = exp_start_q;
   assign done       = done_q;
   assign keys_valid = keys_valid_q;
   assign rk_rd_data = rd_data_q;

endmodule
